micro_sequencer: RTL and testbench

- Next-state logic for the microprogrammed multicycle CPU controller.
- Holds the 4-bit microstate register that addresses the microinstruction ROM.
- Selects the next state from the ROM's AddrCtl field, the instruction opcode and a memory-stall input.
- Traps illegal opcodes and counts retired instruction fetches.

---
 rtl/micro_sequencer_pkg.sv | 53 +++++
 rtl/micro_sequencer_dispatch_rom.sv | 40 ++++
 rtl/micro_sequencer.sv | 100 ++++++++++
 tb/tb_micro_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared encodings for the microprogrammed controller: addr_ctl, opcodes, microstates.
// Latency: none (constants and types only).
// Backpressure: n/a; mem_stall handling lives in micro_sequencer.
package micro_sequencer_pkg;

  localparam int STATE_W_DEF = 4;
  localparam int CNT_W_DEF   = 16;
  localparam int OPCODE_W    = 6;

  // Next-address control field of the microinstruction
  typedef enum logic [1:0] {
    AC_FETCH = 2'b00,
    AC_DISP1 = 2'b01,
    AC_DISP2 = 2'b10,
    AC_SEQ   = 2'b11
  } addr_ctl_e;

  // Selects which dispatch table the ROM consults
  typedef enum logic {
    DISP_TBL1 = 1'b0,
    DISP_TBL2 = 1'b1
  } disp_sel_e;

  // IR[31:26] values recognised by the dispatch tables
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  // Microstates; the value is the microinstruction ROM address
  typedef enum logic [3:0] {
    S_FETCH        = 4'd0,
    S_DECODE       = 4'd1,
    S_MEM_ADDR     = 4'd2,
    S_MEM_READ     = 4'd3,
    S_MEM_WB       = 4'd4,
    S_MEM_WRITE    = 4'd5,
    S_EXECUTE      = 4'd6,
    S_ALU_WB       = 4'd7,
    S_BEQ          = 4'd8,
    S_JUMP         = 4'd9,
    S_ADDI_EXEC    = 4'd10,
    S_ADDI_WB      = 4'd11,
    S_BNE          = 4'd12,
    S_BNE_COMPLETE = 4'd13,
    S_SPARE        = 4'd14,
    S_TRAP         = 4'd15
  } ustate_e;

endpackage

// File: rtl/micro_sequencer_dispatch_rom.sv
// Dispatch tables: maps opcode + table select to a target microstate and an illegal flag.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is used (stall, addr_ctl).
module micro_sequencer_dispatch_rom
  import micro_sequencer_pkg::*;
#(
  parameter int                 STATE_W    = STATE_W_DEF,
  parameter logic [STATE_W-1:0] TRAP_STATE = 4'd15
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_table_sel,
  output logic [STATE_W-1:0]  o_target,
  output logic                o_illegal
);

  // Table lookup; unmatched (including unknown) opcodes fall to the trap default
  always_comb begin
    o_target  = TRAP_STATE;
    o_illegal = 1'b1;
    if (i_table_sel == DISP_TBL1) begin
      case (i_opcode)
        OP_RTYPE: begin o_target = STATE_W'(S_EXECUTE);   o_illegal = 1'b0; end
        OP_LW:    begin o_target = STATE_W'(S_MEM_ADDR);  o_illegal = 1'b0; end
        OP_SW:    begin o_target = STATE_W'(S_MEM_ADDR);  o_illegal = 1'b0; end
        OP_BEQ:   begin o_target = STATE_W'(S_BEQ);       o_illegal = 1'b0; end
        OP_BNE:   begin o_target = STATE_W'(S_BNE);       o_illegal = 1'b0; end
        OP_J:     begin o_target = STATE_W'(S_JUMP);      o_illegal = 1'b0; end
        OP_ADDI:  begin o_target = STATE_W'(S_ADDI_EXEC); o_illegal = 1'b0; end
        default:  begin o_target = TRAP_STATE;            o_illegal = 1'b1; end
      endcase
    end else begin
      case (i_opcode)
        OP_LW:    begin o_target = STATE_W'(S_MEM_READ);  o_illegal = 1'b0; end
        OP_SW:    begin o_target = STATE_W'(S_MEM_WRITE); o_illegal = 1'b0; end
        default:  begin o_target = TRAP_STATE;            o_illegal = 1'b1; end
      endcase
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microsequencer: microstate register, next-address select, illegal trap, fetch counter.
// Latency: next state visible on state one cycle after the edge; all outputs registered.
// Backpressure: mem_stall=1 freezes state and fetch_count; TRAP_STATE holds until reset.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  // STATE_W must stay 4: it is the ROM address width and the ustate_e width
  parameter int                 STATE_W    = STATE_W_DEF,
  parameter int                 CNT_W      = CNT_W_DEF,
  parameter logic [STATE_W-1:0] TRAP_STATE = 4'd15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [1:0]          addr_ctl,
  input  logic                mem_stall,
  output logic [STATE_W-1:0]  state,
  output logic                illegal,
  output logic [CNT_W-1:0]    fetch_count
);

  ustate_e            r_state;
  ustate_e            w_next_state;
  logic               r_illegal;
  logic               w_set_illegal;
  logic [CNT_W-1:0]   r_fetch_count;
  logic               w_rom_sel;
  logic [STATE_W-1:0] w_rom_target;
  logic               w_rom_illegal;
  logic               w_in_trap;

  // addr_ctl 01 -> table 1, 10 -> table 2; other codes ignore the ROM result
  assign w_rom_sel = addr_ctl[1];
  assign w_in_trap = (r_state == TRAP_STATE);

  micro_sequencer_dispatch_rom #(
    .STATE_W    (STATE_W),
    .TRAP_STATE (TRAP_STATE)
  ) u_dispatch_rom (
    .i_opcode    (opcode),
    .i_table_sel (w_rom_sel),
    .o_target    (w_rom_target),
    .o_illegal   (w_rom_illegal)
  );

  // Next-state select: trap sink first, then stall, then addr_ctl
  always_comb begin
    w_next_state  = r_state;
    w_set_illegal = 1'b0;
    if (w_in_trap) begin
      w_next_state = r_state;
    end else if (!mem_stall) begin
      case (addr_ctl)
        AC_FETCH: w_next_state = S_FETCH;
        AC_DISP1: begin
          w_next_state  = ustate_e'(w_rom_target);
          w_set_illegal = w_rom_illegal;
        end
        AC_DISP2: begin
          w_next_state  = ustate_e'(w_rom_target);
          w_set_illegal = w_rom_illegal;
        end
        AC_SEQ:   w_next_state = ustate_e'(r_state + 4'd1);
        default:  w_next_state = r_state;
      endcase
    end
  end

  // Microstate register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Sticky illegal flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_illegal <= 1'b0;
    end else if (w_set_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  // Counts unstalled edges spent in the fetch state; wraps silently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_count <= '0;
    end else if (!mem_stall && (r_state == S_FETCH)) begin
      r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  assign state       = r_state;
  assign illegal     = r_illegal;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: dispatch, trap, stall, counter wrap, async reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Bounded by a free-running clock plus a watchdog.
module tb_micro_sequencer;

  logic        clk;
  logic        reset_n;
  logic [5:0]  opcode;
  logic [1:0]  addr_ctl;
  logic        mem_stall;
  logic [3:0]  state;
  logic        illegal;
  logic [15:0] fetch_count;

  int checks;
  int failures;

  micro_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .addr_ctl    (addr_ctl),
    .mem_stall   (mem_stall),
    .state       (state),
    .illegal     (illegal),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    opcode    = 6'b000000;
    addr_ctl  = 2'b00;
    mem_stall = 1'b0;
    #2;
    reset_n   = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b1;
    opcode    = 6'b000000;
    addr_ctl  = 2'b11;
    mem_stall = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
    checks++;
    if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%0b want=0", illegal); end
    checks++;
    if (fetch_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", fetch_count); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL reset_held_state got=%0d want=0", state); end
  endtask

  task automatic test_lw_sequence();
    logic [1:0] ac_tbl [5] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [3:0] st_tbl [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    do_reset();
    opcode = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      addr_ctl = ac_tbl[i];
      step();
      checks++;
      if (state !== st_tbl[i]) begin
        failures++; $display("FAIL lw_seq[%0d] state got=%0d want=%0d", i, state, st_tbl[i]);
      end
    end
    checks++;
    if (fetch_count !== 16'd1) begin failures++; $display("FAIL lw_count_mid got=%0d want=1", fetch_count); end
    addr_ctl = 2'b00;
    step();
    checks++;
    if (fetch_count !== 16'd2) begin failures++; $display("FAIL lw_count_end got=%0d want=2", fetch_count); end
    checks++;
    if (illegal !== 1'b0) begin failures++; $display("FAIL lw_illegal got=%0b want=0", illegal); end
  endtask

  task automatic test_bne_dispatch();
    do_reset();
    opcode   = 6'b000101;
    addr_ctl = 2'b11;
    step();
    addr_ctl = 2'b01;
    step();
    checks++;
    if (state !== 4'd12) begin failures++; $display("FAIL bne_disp state got=%0d want=12", state); end
    addr_ctl = 2'b00;
    step();
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL bne_fetch state got=%0d want=0", state); end
  endtask

  task automatic test_dispatch_table();
    logic [5:0] op_tbl [5] = '{6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b101011};
    logic [3:0] st_tbl [5] = '{4'd6, 4'd8, 4'd9, 4'd10, 4'd2};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      opcode   = op_tbl[i];
      addr_ctl = 2'b11;
      step();
      addr_ctl = 2'b01;
      step();
      checks++;
      if (state !== st_tbl[i]) begin
        failures++; $display("FAIL disp1[%0d] state got=%0d want=%0d", i, state, st_tbl[i]);
      end
      addr_ctl = 2'b00;
      step();
    end
    checks++;
    if (illegal !== 1'b0) begin failures++; $display("FAIL disp1_illegal got=%0b want=0", illegal); end
    checks++;
    if (fetch_count !== 16'd5) begin failures++; $display("FAIL disp1_count got=%0d want=5", fetch_count); end
  endtask

  task automatic test_illegal_trap();
    logic [1:0] ac_tbl [5] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
    do_reset();
    addr_ctl = 2'b11;
    step();
    opcode   = 6'b111111;
    addr_ctl = 2'b01;
    step();
    checks++;
    if (state !== 4'd15) begin failures++; $display("FAIL trap_entry state got=%0d want=15", state); end
    checks++;
    if (illegal !== 1'b1) begin failures++; $display("FAIL trap_illegal got=%0b want=1", illegal); end
    for (int i = 0; i < 5; i++) begin
      addr_ctl  = ac_tbl[i];
      mem_stall = i[0];
      step();
      checks++;
      if (state !== 4'd15 || illegal !== 1'b1) begin
        failures++; $display("FAIL trap_hold[%0d] state/illegal got=%0d/%0b want=15/1", i, state, illegal);
      end
    end
    mem_stall = 1'b0;
    reset_n   = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      failures++; $display("FAIL trap_async_reset state/illegal got=%0d/%0b want=0/0", state, illegal);
    end
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_disp2_illegal();
    do_reset();
    opcode   = 6'b100011;
    addr_ctl = 2'b11;
    step();
    addr_ctl = 2'b01;
    step();
    opcode   = 6'b000100;
    addr_ctl = 2'b10;
    step();
    checks++;
    if (state !== 4'd15 || illegal !== 1'b1) begin
      failures++; $display("FAIL disp2_trap state/illegal got=%0d/%0b want=15/1", state, illegal);
    end
  endtask

  task automatic test_stall_dispatch();
    do_reset();
    opcode   = 6'b101011;
    addr_ctl = 2'b11;
    step();
    addr_ctl = 2'b01;
    step();
    checks++;
    if (state !== 4'd2) begin failures++; $display("FAIL stall_pre state got=%0d want=2", state); end
    opcode    = 6'b100011;
    addr_ctl  = 2'b10;
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state !== 4'd2 || fetch_count !== 16'd1) begin
        failures++; $display("FAIL stall_hold[%0d] state/count got=%0d/%0d want=2/1", i, state, fetch_count);
      end
    end
    opcode    = 6'b101011;
    mem_stall = 1'b0;
    step();
    checks++;
    if (state !== 4'd5 || fetch_count !== 16'd1) begin
      failures++; $display("FAIL stall_release state/count got=%0d/%0d want=5/1", state, fetch_count);
    end
    addr_ctl  = 2'b00;
    step();
    mem_stall = 1'b1;
    repeat (2) step();
    checks++;
    if (state !== 4'd0 || fetch_count !== 16'd1) begin
      failures++; $display("FAIL stall_fetch state/count got=%0d/%0d want=0/1", state, fetch_count);
    end
    mem_stall = 1'b0;
  endtask

  task automatic test_fetch_wrap();
    do_reset();
    addr_ctl = 2'b00;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    checks++;
    if (fetch_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_max got=%h want=ffff", fetch_count); end
    step();
    checks++;
    if (fetch_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h want=0000", fetch_count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    opcode   = 6'b000100;
    addr_ctl = 2'b11;
    step();
    addr_ctl = 2'b01;
    step();
    checks++;
    if (state !== 4'd8) begin failures++; $display("FAIL mid_pre state got=%0d want=8", state); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || fetch_count !== 16'd0) begin
      failures++;
      $display("FAIL mid_async state/illegal/count got=%0d/%0b/%0d want=0/0/0", state, illegal, fetch_count);
    end
    #1;
    reset_n  = 1'b1;
    addr_ctl = 2'b11;
    step();
    checks++;
    if (state !== 4'd1 || fetch_count !== 16'd1) begin
      failures++; $display("FAIL mid_post state/count got=%0d/%0d want=1/1", state, fetch_count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_lw_sequence();
    test_bne_dispatch();
    test_dispatch_table();
    test_illegal_trap();
    test_disp2_illegal();
    test_stall_dispatch();
    test_mid_reset();
    test_fetch_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
